fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: QUEUE_DEPTH, 4, prefetch queue entries; power of two, 2..16.
REQ-003 Port: clk  input  1  sole clock, all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 Port: imem_req_addr  output  32  word-aligned fetch address.
REQ-007 Port: imem_req_ready  input  1  memory accepts request.
REQ-008 Port: imem_resp_valid  input  1  response word valid; responses return in request order, latency >= 1 cycle.
REQ-009 Port: imem_resp_data  input  32  instruction word.
REQ-010 Port: redirect_valid  input  1  branch/jump redirect from execute, single-cycle pulse.
REQ-011 Port: redirect_pc  input  32  redirect target.
REQ-012 Port: inst_valid  output  1  instruction available to decode.
REQ-013 Port: inst_data  output  32  instruction word at queue head.
REQ-014 Port: inst_pc  output  32  address of inst_data.
REQ-015 Port: inst_ready  input  1  decode consumes head.

Function
REQ-016 Request handshake: transfer when imem_req_valid && imem_req_ready; fetch_pc advances by 4 on each transfer.
REQ-017 fetch_pc arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-018 imem_req_valid SHALL be high only when (queue occupancy + in-flight count) < QUEUE_DEPTH and redirect_valid is low.
REQ-019 imem_req_valid and imem_req_addr SHALL stay stable while imem_req_ready is low, except on redirect.
REQ-020 In-flight counter: +1 on request transfer, -1 on response, both in one cycle -> unchanged.
REQ-021 Each accepted response SHALL be pushed into the queue with its request PC, unless dropped (REQ-024).
REQ-022 Queue output registered: response in cycle N -> inst_valid earliest in cycle N+1; no bypass.
REQ-023 Decode handshake: pop when inst_valid && inst_ready; push and pop in one cycle on a full queue SHALL be legal.
REQ-024 Redirect (cycle N): queue flushed, drop counter loaded with in-flight count minus any response in cycle N, fetch_pc = {redirect_pc[31:2],2'b00}; subsequent responses discarded while drop counter nonzero, decrementing by 1.
REQ-025 After redirect, inst_valid SHALL be low in cycle N+1; first request to new target issued no earlier than cycle N+1.
REQ-026 Redirect concurrent with pop: pop ignored, flush wins.
REQ-027 Queue overflow and in-flight underflow impossible by construction; simulation assertion SHALL flag either.

Reset
REQ-028 On rst: fetch_pc = RESET_PC, queue empty, in-flight = 0, drop counter = 0.
REQ-029 During rst: imem_req_valid = 0, inst_valid = 0, inst_data = 0, inst_pc = 0.
REQ-030 Reset mid-operation: all in-flight responses forgotten; responses arriving after rst release are not guaranteed to be dropped, memory is reset together with the block.
REQ-031 First request SHALL be issued in the first cycle after rst deasserts.

Structure
REQ-032 XLEN (32) and INST_NOP (32'h0000_0013) constants in riscv_package; fetch_unit imports it.
REQ-033 Queue entry struct (pc, inst) typedef in riscv_package as fetch_entry_t.
REQ-034 One sub-module: fetch_queue, parameterised sync FIFO with flush, push, pop, full, empty, count.

Verification
REQ-035 Reset release, memory always ready, latency 1, decode always ready -> inst_pc sequence 0,4,8,12 with matching data; first inst_valid cycle 3 after release.
REQ-036 Decode ready held low for 20 cycles -> exactly QUEUE_DEPTH=4 requests issued, imem_req_valid low thereafter, no data lost on resume.
REQ-037 Latency 3, redirect to 32'h0000_0100 with 2 in flight -> both stale responses dropped, next inst_pc = 32'h100.
REQ-038 RESET_PC = 32'hFFFF_FFF8 -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 redirect_pc = 32'h0000_0203 -> fetch at 32'h0000_0200; redirect on same cycle as pop -> flush wins, queue empty next cycle.
REQ-040 rst asserted with queue full and 2 in flight -> outputs low asynchronously, restart from RESET_PC.

Source files
------------

// File: rtl/riscv_package.sv
// Shared constants and types for the instruction fetch path.
// The fetch unit and its prefetch queue both import this package.
package riscv_package;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Clears the byte offset so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO holding (pc, inst) pairs for decode.
// Flush empties it in one cycle and overrides any push or pop that cycle.
module fetch_queue
    import riscv_package::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);

    fetch_entry_t storage [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic do_push;
    logic do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A pop frees a slot in the same cycle, so push-while-full is accepted.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            storage[wr_ptr] <= push_entry;
        end
    end

    // Head reads as zero when empty so decode never sees stale entries.
    assign head = empty ? '0 : storage[rd_ptr];

    a_queue_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned requests, tracks in-flight
// responses, buffers them with their PCs and discards stale ones after a redirect.
module fetch_unit
    import riscv_package::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // a raised valid and its payload hold until that edge, except that a
    // redirect may withdraw the request.

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   q_count;
    logic [CW:0]     occupancy;
    logic            req_fire;
    logic            resp_drop;
    logic            q_push;
    logic            q_pop;
    logic            q_full;
    logic            q_empty;
    fetch_entry_t    q_entry;
    fetch_entry_t    q_head;

    // Counting in-flight words against free slots guarantees every response has room.
    assign occupancy      = {1'b0, q_count} + {1'b0, inflight};
    assign imem_req_valid = !rst && !redirect_valid && (occupancy < (CW + 1)'(QUEUE_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_drop = imem_resp_valid && (drop_cnt != '0);
    assign q_push    = imem_resp_valid && !resp_drop && !redirect_valid;
    assign q_pop     = inst_valid && inst_ready && !redirect_valid;

    assign q_entry.pc   = resp_pc;
    assign q_entry.inst = imem_resp_data;

    // resp_pc is the address of the next response that will be kept, so it
    // only advances on kept responses and jumps to the target on a redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= align_pc(RESET_PC);
            resp_pc  <= align_pc(RESET_PC);
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight + CW'(req_fire) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                fetch_pc <= align_pc(redirect_pc);
                resp_pc  <= align_pc(redirect_pc);
                drop_cnt <= inflight - CW'(imem_resp_valid);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (resp_drop) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end else if (imem_resp_valid) begin
                    resp_pc <= resp_pc + 32'd4;
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (q_push),
        .push_entry (q_entry),
        .pop        (q_pop),
        .head       (q_head),
        .full       (q_full),
        .empty      (q_empty),
        .count      (q_count)
    );

    assign inst_valid = !q_empty;
    assign inst_data  = q_head.inst;
    assign inst_pc    = q_head.pc;

    a_no_inflight_underflow: assert property (@(posedge clk) disable iff (rst)
        !(imem_resp_valid && (inflight == '0)));

    a_no_queue_overflow: assert property (@(posedge clk) disable iff (rst)
        !(q_push && q_full && !q_pop));

    a_drop_within_inflight: assert property (@(posedge clk) disable iff (rst)
        drop_cnt <= inflight);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with programmable latency,
// decode-side scoreboard of expected PCs, one task per scenario.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] resp_data_w;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_ready;

    logic        imem_req_valid, req_valid_w;
    logic [31:0] imem_req_addr, req_addr_w;
    logic        inst_valid, inst_valid_w;
    logic [31:0] inst_data, inst_data_w;
    logic [31:0] inst_pc, inst_pc_w;

    logic [31:0] exp_q[$];
    logic [31:0] exp_w_q[$];
    logic [31:0] pend_q[$];
    logic [31:0] pend_w_q[$];
    int          due_q[$];

    int cyc = 0;
    int lat = 1;
    int req_count = 0;
    int pass_cnt = 0;
    int total_cnt = 0;
    bit wrap_chk = 1'b0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_data(inst_data),
        .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(4)) dut_wrap (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid_w), .imem_req_addr(req_addr_w),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(resp_data_w), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid_w), .inst_data(inst_data_w),
        .inst_pc(inst_pc_w), .inst_ready(inst_ready)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required end before 500000");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // memory model: in-order, response lat cycles after the accepting edge
    always @(negedge clk) begin
        if (rst) begin
            pend_q.delete();
            pend_w_q.delete();
            due_q.delete();
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
            resp_data_w     = '0;
        end else begin
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(pend_q.pop_front());
                resp_data_w     = mem_word(pend_w_q.pop_front());
                void'(due_q.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
            end
            if (imem_req_valid && imem_req_ready) begin
                pend_q.push_back(imem_req_addr);
                pend_w_q.push_back(req_addr_w);
                due_q.push_back(cyc + lat);
                req_count = req_count + 1;
            end
        end
    end

    // scoreboard: compare every decode handshake against the expected queue
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && inst_valid && inst_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_inst: got pc %h, required no instruction", inst_pc);
            end else begin
                e = exp_q.pop_front();
                total_cnt++;
                if (inst_pc !== e) $display("FAIL inst_pc: got %h, required %h", inst_pc, e);
                else pass_cnt++;
                total_cnt++;
                if (inst_data !== mem_word(e))
                    $display("FAIL inst_data@%h: got %h, required %h", e, inst_data, mem_word(e));
                else pass_cnt++;
            end
        end
        if (wrap_chk && !rst && inst_valid_w && inst_ready && !redirect_valid) begin
            if (exp_w_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_wrap_inst: got pc %h, required no instruction", inst_pc_w);
            end else begin
                e = exp_w_q.pop_front();
                total_cnt++;
                if (inst_pc_w !== e) $display("FAIL wrap_inst_pc: got %h, required %h", inst_pc_w, e);
                else pass_cnt++;
                total_cnt++;
                if (inst_data_w !== mem_word(e))
                    $display("FAIL wrap_inst_data@%h: got %h, required %h", e, inst_data_w, mem_word(e));
                else pass_cnt++;
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        req_count = 0;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || (wrap_chk && exp_w_q.size() != 0)) && t < 200) begin
            step();
            t++;
        end
        inst_ready = 1'b0;
        total_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL %s_drain: got %0d instructions outstanding, required 0", name, exp_q.size());
        else pass_cnt++;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b0;
        repeat (2) step();
        total_cnt++;
        if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b, required 0", imem_req_valid);
        else pass_cnt++;
        total_cnt++;
        if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid: got %b, required 0", inst_valid);
        else pass_cnt++;
        total_cnt++;
        if (inst_data !== 32'h0) $display("FAIL reset_inst_data: got %h, required 0", inst_data);
        else pass_cnt++;
        total_cnt++;
        if (inst_pc !== 32'h0) $display("FAIL reset_inst_pc: got %h, required 0", inst_pc);
        else pass_cnt++;
    endtask

    task automatic test_sequential();
        int first = 0;
        lat = 1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        push_seq(32'h0, 6);
        exp_w_q.push_back(32'hFFFF_FFF8);
        exp_w_q.push_back(32'hFFFF_FFFC);
        exp_w_q.push_back(32'h0000_0000);
        exp_w_q.push_back(32'h0000_0004);
        exp_w_q.push_back(32'h0000_0008);
        exp_w_q.push_back(32'h0000_000C);
        wrap_chk = 1'b1;
        do_reset();
        @(negedge clk);
        total_cnt++;
        if (imem_req_valid !== 1'b1) $display("FAIL first_req_valid: got %b, required 1", imem_req_valid);
        else pass_cnt++;
        total_cnt++;
        if (imem_req_addr !== 32'h0) $display("FAIL first_req_addr: got %h, required 0", imem_req_addr);
        else pass_cnt++;
        for (int k = 1; k <= 10 && first == 0; k++) begin
            if (k > 1) @(negedge clk);
            if (inst_valid) first = k;
        end
        total_cnt++;
        if (first != 3) $display("FAIL first_inst_cycle: got %0d, required 3", first);
        else pass_cnt++;
        wait_drain("sequential");
        total_cnt++;
        if (exp_w_q.size() != 0)
            $display("FAIL wrap_drain: got %0d outstanding, required 0", exp_w_q.size());
        else pass_cnt++;
        exp_w_q.delete();
        wrap_chk = 1'b0;
    endtask

    task automatic test_backpressure();
        lat = 1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;
        do_reset();
        repeat (20) step();
        total_cnt++;
        if (req_count != 4) $display("FAIL stall_req_count: got %0d, required 4", req_count);
        else pass_cnt++;
        total_cnt++;
        if (imem_req_valid !== 1'b0) $display("FAIL stall_req_valid: got %b, required 0", imem_req_valid);
        else pass_cnt++;
        push_seq(32'h0, 8);
        inst_ready = 1'b1;
        wait_drain("backpressure");
    endtask

    task automatic test_redirect();
        int t = 0;
        lat = 3;
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;
        do_reset();
        while (req_count < 2 && t < 20) begin
            step();
            t++;
        end
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        @(negedge clk);
        total_cnt++;
        if (imem_req_valid !== 1'b0) $display("FAIL redirect_req_valid: got %b, required 0", imem_req_valid);
        else pass_cnt++;
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (inst_valid !== 1'b0) $display("FAIL redirect_flush: got %b, required 0", inst_valid);
        else pass_cnt++;
        total_cnt++;
        if (imem_req_addr !== 32'h100) $display("FAIL redirect_addr: got %h, required 00000100", imem_req_addr);
        else pass_cnt++;
        step();
        push_seq(32'h100, 4);
        inst_ready = 1'b1;
        wait_drain("redirect");
    endtask

    task automatic test_align_flush();
        lat = 1;
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;
        do_reset();
        repeat (7) step();
        total_cnt++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0)
            $display("FAIL full_head: got valid %b pc %h, required valid 1 pc 0", inst_valid, inst_pc);
        else pass_cnt++;
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0203;
        step();
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (inst_valid !== 1'b0) $display("FAIL flush_wins: got %b, required 0", inst_valid);
        else pass_cnt++;
        total_cnt++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200)
            $display("FAIL aligned_addr: got valid %b addr %h, required valid 1 addr 00000200",
                     imem_req_valid, imem_req_addr);
        else pass_cnt++;
        step();
        push_seq(32'h200, 3);
        inst_ready = 1'b1;
        wait_drain("align");
    endtask

    task automatic test_reset_midop();
        lat = 3;
        imem_req_ready = 1'b1;
        inst_ready = 1'b0;
        do_reset();
        repeat (5) step();
        total_cnt++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || imem_req_valid !== 1'b0)
            $display("FAIL midop_state: got valid %b pc %h req %b, required 1 00000000 0",
                     inst_valid, inst_pc, imem_req_valid);
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0)
            $display("FAIL async_reset_valid: got req %b inst %b, required 0 0", imem_req_valid, inst_valid);
        else pass_cnt++;
        total_cnt++;
        if (inst_data !== 32'h0 || inst_pc !== 32'h0)
            $display("FAIL async_reset_data: got data %h pc %h, required 0 0", inst_data, inst_pc);
        else pass_cnt++;
        lat = 1;
        push_seq(32'h0, 3);
        inst_ready = 1'b1;
        do_reset();
        wait_drain("reset_midop");
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_align_flush();
        test_reset_midop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
